// File: rtl/maxpool_window_buffer.sv
// rtl/maxpool_window_buffer.sv - frame buffer with 2x2 stride-2 max pooling
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input sample handshake, accepted only while filling
//   in_data               conv result, raster order (ch, row, col)
//   out_valid/out_ready   pooled result handshake
//   out_data, out_ch      window maximum and its channel
//   out_last              marks the final window of the frame
//   busy                  high while pooling (not filling)
//   frame_done            one-cycle pulse after the final output handshake

module maxpool_window_buffer #(
    parameter int N_C    = 26,
    parameter int N_R    = 26,
    parameter int N_CH   = 1,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int CH_W   = 1,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done
);

    localparam int DEPTH = N_C * N_R * N_CH;
    localparam int NWC   = N_C / 2;
    localparam int NWR   = N_R / 2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PLANE     = ADDR_W'(N_R * N_C);
    localparam logic [ADDR_W-1:0] ROW       = ADDR_W'(N_C);
    localparam logic [ADDR_W-1:0] ROW2      = ADDR_W'(2 * N_C);
    localparam logic [ADDR_W-1:0] WC_LAST   = ADDR_W'(NWC - 1);
    localparam logic [ADDR_W-1:0] WR_LAST   = ADDR_W'(NWR - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {FILL, RD, MAX, OUT} state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] wc;
    logic [ADDR_W-1:0] wr;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] w0, w1, w2, w3;
    logic [DATA_W-1:0] m01, m23, mx;
    logic [ADDR_W-1:0] base;
    logic              in_fire;
    logic              out_fire;
    logic              last_word;
    logic              last_win;

    assign in_ready  = rst_n && (state == FILL);
    assign busy      = (state != FILL);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_word = (wp == LAST_ADDR);
    assign last_win  = (wc == WC_LAST) && (wr == WR_LAST) && (ch == CH_LAST);

    // Top-left corner of the current window; odd trailing row/column never reached.
    assign base = ADDR_W'(ch) * PLANE + wr * ROW2 + (wc << 1);

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    assign m01 = gt(w1, w0) ? w1 : w0;
    assign m23 = gt(w3, w2) ? w3 : w2;
    assign mx  = gt(m23, m01) ? m23 : m01;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL: if (in_fire && last_word) state_nx = RD;
            RD:   state_nx = MAX;
            MAX:  state_nx = OUT;
            OUT:  if (out_fire) state_nx = last_win ? FILL : RD;
            default: state_nx = FILL;
        endcase
    end

    // Storage is deliberately left out of reset: a new frame always overwrites it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wp] <= in_data;
        end
        if (state == RD) begin
            w0 <= mem[base];
            w1 <= mem[base + 1'b1];
            w2 <= mem[base + ROW];
            w3 <= mem[base + ROW + 1'b1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            wc         <= '0;
            wr         <= '0;
            ch         <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (in_fire) begin
                if (last_word) begin
                    wp <= '0;
                    wc <= '0;
                    wr <= '0;
                    ch <= '0;
                end else begin
                    wp <= wp + 1'b1;
                end
            end
            if (state == MAX) begin
                out_data  <= mx;
                out_ch    <= ch;
                out_valid <= 1'b1;
                out_last  <= last_win;
            end
            if ((state == OUT) && out_fire) begin
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
                frame_done <= last_win;
                if (wc == WC_LAST) begin
                    wc <= '0;
                    if (wr == WR_LAST) begin
                        wr <= '0;
                        ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                    end else begin
                        wr <= wr + 1'b1;
                    end
                end else begin
                    wc <= wc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_window_buffer.sv
// tb/tb_maxpool_window_buffer.sv - self-checking bench for maxpool_window_buffer

module tb_maxpool_window_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       out_ready;
    logic       iv [5];
    logic       ir [5];
    logic       ov [5];
    logic       ol [5];
    logic       bz [5];
    logic       fd [5];
    logic [7:0] od [5];
    logic [0:0] oc [5];

    always #5 clk = ~clk;

    // u0 default, u1/u2 2x2 signed/unsigned, u3 5x5, u4 two channels
    maxpool_window_buffer #(.N_C(26), .N_R(26), .N_CH(1), .DATA_W(8), .ADDR_W(10), .CH_W(1), .SIGNED(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(in_data), .in_ready(ir[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_ch(oc[0]), .out_last(ol[0]), .busy(bz[0]), .frame_done(fd[0]));
    maxpool_window_buffer #(.N_C(2), .N_R(2), .N_CH(1), .DATA_W(8), .ADDR_W(2), .CH_W(1), .SIGNED(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(in_data), .in_ready(ir[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_ch(oc[1]), .out_last(ol[1]), .busy(bz[1]), .frame_done(fd[1]));
    maxpool_window_buffer #(.N_C(2), .N_R(2), .N_CH(1), .DATA_W(8), .ADDR_W(2), .CH_W(1), .SIGNED(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_data(in_data), .in_ready(ir[2]), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_ch(oc[2]), .out_last(ol[2]), .busy(bz[2]), .frame_done(fd[2]));
    maxpool_window_buffer #(.N_C(5), .N_R(5), .N_CH(1), .DATA_W(8), .ADDR_W(5), .CH_W(1), .SIGNED(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_data(in_data), .in_ready(ir[3]), .out_valid(ov[3]),
        .out_ready(out_ready), .out_data(od[3]), .out_ch(oc[3]), .out_last(ol[3]), .busy(bz[3]), .frame_done(fd[3]));
    maxpool_window_buffer #(.N_C(26), .N_R(26), .N_CH(2), .DATA_W(8), .ADDR_W(11), .CH_W(1), .SIGNED(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_data(in_data), .in_ready(ir[4]), .out_valid(ov[4]),
        .out_ready(out_ready), .out_data(od[4]), .out_ch(oc[4]), .out_last(ol[4]), .busy(bz[4]), .frame_done(fd[4]));

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       l;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       cur;
    logic [7:0] mem_m [$];
    logic [7:0] outs_d [$];
    logic       outs_c [$];

    int checks = 0;
    int errors = 0;
    int sel = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fgot = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;
    bit mon_en = 1'b0;
    bit stalled = 1'b0;
    bit stall_prev = 1'b0;
    bit last_hs_prev = 1'b0;
    logic [7:0] hold_d;
    logic       hold_c;
    logic       hold_l;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int sval(input logic [7:0] v, input bit sgn);
        return sgn ? int'($signed(v)) : int'(v);
    endfunction

    // Expected output list straight from the pooling rule over mem_m.
    task automatic build(input int nc, input int nr, input int nch, input bit sgn);
        exp_q.delete();
        for (int c = 0; c < nch; c++) begin
            for (int r = 0; r < nr / 2; r++) begin
                for (int k = 0; k < nc / 2; k++) begin
                    int   b;
                    int   best;
                    int   offs [3];
                    exp_t e;
                    b = c * nr * nc + 2 * r * nc + 2 * k;
                    offs = '{1, nc, nc + 1};
                    best = sval(mem_m[b], sgn);
                    for (int j = 0; j < 3; j++) begin
                        if (sval(mem_m[b + offs[j]], sgn) > best) best = sval(mem_m[b + offs[j]], sgn);
                    end
                    e.d = best[7:0];
                    e.c = c[0];
                    e.l = (c == nch - 1) && (r == nr / 2 - 1) && (k == nc / 2 - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic start(input int k, input int nc, input int nr, input int nch, input bit sgn);
        build(nc, nr, nch, sgn);
        sel = k;
        outs_d.delete();
        outs_c.delete();
        fgot = 0;
        stalled = 1'b0;
        stall_prev = 1'b0;
        last_hs_prev = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic send_frame(input int k);
        for (int i = 0; i < mem_m.size(); i++) begin
            int t = 0;
            while (!ir[k] && t < 3000) begin
                @(posedge clk); #1;
                t++;
            end
            if (t == 3000) chk("in_ready_timeout", int'(ir[k]), 1);
            in_data = mem_m[i];
            iv[k] = 1'b1;
            @(posedge clk); #1;
        end
        iv[k] = 1'b0;
    endtask

    task automatic wait_done();
        int start_cnt = fd_cnt;
        int t = 0;
        while (fd_cnt == start_cnt && t < 20000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("frame_done_seen", fd_cnt - start_cnt, 1);
        chk("outputs_outstanding", exp_q.size(), 0);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("in_ready_vs_busy", int'(ir[sel]), int'(!bz[sel]));
            chk("frame_done_pulse", int'(fd[sel]), int'(last_hs_prev));
            if (fd[sel]) fd_cnt++;
            last_hs_prev = 1'b0;
            if (iv[sel] && ir[sel]) acc_cyc = cyc;
            if (stall_prev) begin
                chk("hold_valid", int'(ov[sel]), 1);
                chk("hold_data", int'(od[sel]), int'(hold_d));
                chk("hold_ch", int'(oc[sel]), int'(hold_c));
                chk("hold_last", int'(ol[sel]), int'(hold_l));
            end
            stall_prev = 1'b0;
            if (ov[sel]) begin
                if (!out_ready) begin
                    stall_prev = 1'b1;
                    stalled = 1'b1;
                    hold_d = od[sel];
                    hold_c = oc[sel];
                    hold_l = ol[sel];
                end else begin
                    if (exp_q.size() == 0) begin
                        chk("extra_output", int'(ov[sel]), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("out_data", int'(od[sel]), int'(cur.d));
                        chk("out_ch", int'(oc[sel]), int'(cur.c));
                        chk("out_last", int'(ol[sel]), int'(cur.l));
                    end
                    if (!stalled) chk("handshake_spacing", cyc - ((fgot == 0) ? acc_cyc : hs_cyc), 3);
                    hs_cyc = cyc;
                    stalled = 1'b0;
                    outs_d.push_back(od[sel]);
                    outs_c.push_back(oc[sel][0]);
                    fgot++;
                    if (ol[sel]) begin
                        last_hs_prev = 1'b1;
                        fgot = 0;
                    end
                end
            end
        end
    end

    initial begin
        int lit [4];
        int t;
        for (int k = 0; k < 5; k++) iv[k] = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rst_in_ready", int'(ir[k]), 0);
            chk("rst_out_valid", int'(ov[k]), 0);
            chk("rst_busy", int'(bz[k]), 0);
        end
        chk("rst_out_data", int'(od[0]), 0);
        chk("rst_out_last", int'(ol[0]), 0);
        chk("rst_frame_done", int'(fd[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", int'(ir[0]), 1);
        @(posedge clk); #1;

        // Single +3 among -5s; in_valid pulses while pooling must not write.
        mem_m.delete();
        for (int i = 0; i < 676; i++) mem_m.push_back(8'hFB);
        mem_m[27] = 8'h03;
        start(0, 26, 26, 1, 1'b1);
        send_frame(0);
        in_data = 8'h7F;
        iv[0] = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        wait_done();
        chk("single_max_count", outs_d.size(), 169);
        if (outs_d.size() == 169) begin
            chk("single_max_first", int'(outs_d[0]), 3);
            chk("single_max_last", int'(outs_d[168]), 8'hFB);
        end

        // Address-dependent frame exposes any write-pointer slip; stall output 5.
        mem_m.delete();
        for (int i = 0; i < 676; i++) mem_m.push_back(8'(i * 37 + 11));
        start(0, 26, 26, 1, 1'b1);
        send_frame(0);
        t = 0;
        while (fgot < 4 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b0;
        t = 0;
        while (!ov[0] && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("stall_output_valid", int'(ov[0]), 1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done();
        chk("backpressure_count", outs_d.size(), 169);

        // Signedness on a single 2x2 window {-1, 2, 0, 1}.
        mem_m.delete();
        mem_m.push_back(8'hFF); mem_m.push_back(8'h02); mem_m.push_back(8'h00); mem_m.push_back(8'h01);
        start(1, 2, 2, 1, 1'b1);
        send_frame(1);
        wait_done();
        chk("signed_count", outs_d.size(), 1);
        if (outs_d.size() == 1) chk("signed_max", int'(outs_d[0]), 8'h02);
        start(2, 2, 2, 1, 1'b0);
        send_frame(2);
        wait_done();
        chk("unsigned_count", outs_d.size(), 1);
        if (outs_d.size() == 1) chk("unsigned_max", int'(outs_d[0]), 8'hFF);

        // Odd 5x5: second pass loads the ignored row/column with large values.
        lit = '{6, 8, 16, 18};
        for (int pass = 0; pass < 2; pass++) begin
            mem_m.delete();
            for (int i = 0; i < 25; i++) mem_m.push_back(8'(i));
            if (pass == 1) begin
                for (int j = 0; j < 5; j++) begin
                    mem_m[j * 5 + 4] = 8'h7F;
                    mem_m[20 + j] = 8'h7F;
                end
            end
            start(3, 5, 5, 1, 1'b1);
            send_frame(3);
            wait_done();
            chk("odd_count", outs_d.size(), 4);
            for (int i = 0; i < outs_d.size() && i < 4; i++) chk("odd_value", int'(outs_d[i]), lit[i]);
        end

        // Two channels.
        mem_m.delete();
        for (int i = 0; i < 1352; i++) mem_m.push_back(8'($urandom_range(0, 255)));
        start(4, 26, 26, 2, 1'b1);
        send_frame(4);
        wait_done();
        chk("two_ch_count", outs_d.size(), 338);
        if (outs_c.size() == 338) begin
            chk("two_ch_169", int'(outs_c[168]), 0);
            chk("two_ch_170", int'(outs_c[169]), 1);
        end

        // Reset while output 51 is presented, then a fresh frame.
        mem_m.delete();
        for (int i = 0; i < 676; i++) mem_m.push_back(8'($urandom_range(1, 255)));
        start(0, 26, 26, 1, 1'b1);
        send_frame(0);
        t = 0;
        while (!(fgot == 50 && ov[0]) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("midpool_reached", fgot, 50);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midpool_out_valid", int'(ov[0]), 0);
        chk("midpool_out_data", int'(od[0]), 0);
        chk("midpool_out_ch", int'(oc[0]), 0);
        chk("midpool_busy", int'(bz[0]), 0);
        chk("midpool_in_ready", int'(ir[0]), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midpool_in_ready_release", int'(ir[0]), 1);
        @(posedge clk); #1;
        for (int i = 0; i < 676; i++) mem_m[i] = 8'(i * 13 + 5);
        start(0, 26, 26, 1, 1'b1);
        send_frame(0);
        wait_done();
        chk("fresh_count", outs_d.size(), 169);
        if (outs_d.size() > 0) begin
            int m = int'($signed(mem_m[0]));
            if (int'($signed(mem_m[1])) > m) m = int'($signed(mem_m[1]));
            if (int'($signed(mem_m[26])) > m) m = int'($signed(mem_m[26]));
            if (int'($signed(mem_m[27])) > m) m = int'($signed(mem_m[27]));
            chk("fresh_first_window", int'(outs_d[0]), m & 8'hFF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
